// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM port between NUM_REQ requesters.
// A grant is held for a whole burst; read data returns with a one-hot valid to the issuer.
module ram_port_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BYTE_WIDTH  = 8,
  parameter int unsigned BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            beat_valid_i,
  input  logic [NUM_REQ-1:0]            last_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ*BATCH_WIDTH-1:0] be_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            beat_ready_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [DATA_WIDTH-1:0]         write_o,
  output logic                          write_en_o,
  output logic [BATCH_WIDTH-1:0]        byte_en_o,
  input  logic [DATA_WIDTH-1:0]         data_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int unsigned          cand;

  logic                 g_req, g_valid, g_last, g_we;
  logic [ADDR_WIDTH-1:0]  g_addr;
  logic [DATA_WIDTH-1:0]  g_wdata;
  logic [BATCH_WIDTH-1:0] g_be;
  logic                 accept;

  // State registers; rvalid_q doubles as the pending-read flag and its owner id
  always_ff @(posedge clk_in) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Mux the granted requester's beat fields (grant is one-hot)
  always_comb begin
    g_req   = 1'b0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        g_req   = req_i[k];
        g_valid = beat_valid_i[k];
        g_last  = last_i[k];
        g_we    = we_i[k];
        g_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        g_be    = be_i[k*BATCH_WIDTH +: BATCH_WIDTH];
      end
    end
  end

  // Next-state and RAM port drive
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    rvalid_d     = '0;
    accept       = 1'b0;
    beat_ready_o = '0;
    addr_o       = '0;
    write_o      = '0;
    write_en_o   = 1'b0;
    byte_en_o    = '0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d         = BUSY;
          gnt_d[win_idx]  = 1'b1;
          rr_ptr_d        = win_idx;
        end
      end
      BUSY: begin
        accept       = g_valid;
        beat_ready_o = gnt_q & beat_valid_i;
        addr_o       = g_addr;
        write_o      = g_wdata;
        write_en_o   = accept & g_we;
        if (accept) begin
          byte_en_o = g_we ? g_be : '1;
        end
        if (accept && !g_we) begin
          rvalid_d = gnt_q;
        end
        // Last beat or abandoned request: always drop through one idle bubble
        if ((accept && g_last) || !g_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (rst_i) begin
      beat_ready_o = '0;
      addr_o       = '0;
      write_o      = '0;
      write_en_o   = 1'b0;
      byte_en_o    = '0;
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = data_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small byte-enabled RAM model.
module tb_ram_port_arbiter;

  logic         clk_in = 1'b0;
  logic         rst_i;
  logic [3:0]   req_i, beat_valid_i, last_i, we_i;
  logic [63:0]  addr_i;
  logic [127:0] wdata_i;
  logic [15:0]  be_i;
  logic [3:0]   gnt_o, beat_ready_o, rvalid_o;
  logic [31:0]  rdata_o, write_o, data_i;
  logic [15:0]  addr_o;
  logic         write_en_o;
  logic [3:0]   byte_en_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic [3:0]  exp_gnt [0:8];

  ram_port_arbiter dut (
    .clk_in(clk_in), .rst_i(rst_i), .req_i(req_i), .beat_valid_i(beat_valid_i),
    .last_i(last_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .beat_ready_o(beat_ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .addr_o(addr_o), .write_o(write_o), .write_en_o(write_en_o), .byte_en_o(byte_en_o),
    .data_i(data_i)
  );

  always #5 clk_in = ~clk_in;

  // RAM macro model: byte-enabled write, registered read
  always @(posedge clk_in) begin
    if (write_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_o[b]) mem[addr_o[7:0]][b*8 +: 8] <= write_o[b*8 +: 8];
      end
    end
    data_i <= mem[addr_o[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic idle_in();
    req_i        = '0;
    beat_valid_i = '0;
    last_i       = '0;
    we_i         = '0;
  endtask

  task automatic beat(input int k, input logic we, input logic last,
                      input logic [15:0] a, input logic [31:0] d);
    beat_valid_i[k]        = 1'b1;
    we_i[k]                = we;
    last_i[k]              = last;
    addr_i[k*16 +: 16]     = a;
    wdata_i[k*32 +: 32]    = d;
    be_i[k*4 +: 4]         = 4'hF;
  endtask

  // Structural invariants every cycle
  always @(negedge clk_in) begin
    chk("inv_gnt_onehot0", 64'($onehot0(gnt_o)), 64'd1);
    chk("inv_ready_subset", 64'(beat_ready_o & ~gnt_o), 64'd0);
    if (write_en_o) chk("inv_we_onehot_ready", 64'($onehot(beat_ready_o)), 64'd1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0000; exp_gnt[2] = 4'b0010;
    exp_gnt[3] = 4'b0000; exp_gnt[4] = 4'b0100; exp_gnt[5] = 4'b0000;
    exp_gnt[6] = 4'b1000; exp_gnt[7] = 4'b0000; exp_gnt[8] = 4'b0001;
    idle_in();
    rst_i = 1'b1; addr_i = '0; wdata_i = '0; be_i = '0;

    // 1: reset state and grant latency
    repeat (3) tick();
    sample();
    chk("rst_gnt", gnt_o, 0);          chk("rst_rvalid", rvalid_o, 0);
    chk("rst_ready", beat_ready_o, 0); chk("rst_addr", addr_o, 0);
    chk("rst_wdata", write_o, 0);      chk("rst_we", write_en_o, 0);
    chk("rst_be", byte_en_o, 0);
    tick(); rst_i = 1'b0;
    sample(); chk("t1_idle_gnt", gnt_o, 0);
    tick(); req_i = 4'b0001;
    sample(); chk("t1_gnt_same_cycle", gnt_o, 4'b0000);
    tick();
    sample(); chk("t1_gnt_next_cycle", gnt_o, 4'b0001);
    tick(); req_i = 4'b0000;
    sample(); chk("t1_gnt_held", gnt_o, 4'b0001);
    tick();
    sample(); chk("t1_abandon_gnt", gnt_o, 4'b0000);

    // 2: requester 2 writes 3 beats
    tick(); req_i = 4'b0100; beat(2, 1'b1, 1'b0, 16'h10, 32'hA0);
    sample(); chk("t2_pre_gnt", gnt_o, 0); chk("t2_pre_we", write_en_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); beat(2, 1'b1, (i == 2), 16'(16'h10 + i), 32'(32'hA0 + i));
      sample();
      chk("t2_gnt", gnt_o, 4'b0100);
      chk("t2_ready", beat_ready_o, 4'b0100);
      chk("t2_we", write_en_o, 1);
      chk("t2_addr", addr_o, 16'h10 + i);
      chk("t2_wdata", write_o, 32'hA0 + i);
      chk("t2_be", byte_en_o, 4'hF);
      chk("t2_rvalid", rvalid_o, 0);
    end
    tick(); idle_in();
    sample(); chk("t2_post_gnt", gnt_o, 0); chk("t2_post_we", write_en_o, 0);

    // 3: requester 1 reads 2 beats
    tick(); req_i = 4'b0010; beat(1, 1'b0, 1'b0, 16'h10, 32'h0);
    sample(); chk("t3_pre_gnt", gnt_o, 0);
    tick();
    sample();
    chk("t3_gnt", gnt_o, 4'b0010); chk("t3_ready0", beat_ready_o, 4'b0010);
    chk("t3_we", write_en_o, 0);   chk("t3_be_rd", byte_en_o, 4'hF);
    chk("t3_addr0", addr_o, 16'h10); chk("t3_rv_none", rvalid_o, 0);
    tick(); beat(1, 1'b0, 1'b1, 16'h11, 32'h0);
    sample();
    chk("t3_rvalid0", rvalid_o, 4'b0010); chk("t3_rdata0", rdata_o, 32'hA0);
    chk("t3_ready1", beat_ready_o, 4'b0010); chk("t3_addr1", addr_o, 16'h11);
    tick(); idle_in();
    sample();
    chk("t3_rvalid1", rvalid_o, 4'b0010); chk("t3_rdata1", rdata_o, 32'hA1);
    chk("t3_post_gnt", gnt_o, 0);
    tick();
    sample(); chk("t3_rvalid_end", rvalid_o, 0);

    // 4: all four request single-beat bursts from a fresh pointer
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    tick();
    req_i = 4'b1111; beat_valid_i = 4'b1111; last_i = 4'b1111; we_i = 4'b0000;
    sample(); chk("t4_pre_gnt", gnt_o, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      sample(); chk("t4_gnt_order", gnt_o, exp_gnt[i]);
    end
    tick(); idle_in();
    sample(); chk("t4_post_gnt", gnt_o, 0);

    // 5: requester 3 single read while requester 0 waits
    tick(); req_i = 4'b1001; beat(3, 1'b0, 1'b1, 16'h11, 32'h0);
    sample(); chk("t5_pre_gnt", gnt_o, 0);
    tick();
    sample(); chk("t5_gnt3", gnt_o, 4'b1000); chk("t5_ready3", beat_ready_o, 4'b1000);
    tick(); idle_in(); req_i = 4'b0001;
    sample();
    chk("t5_bubble_gnt", gnt_o, 0); chk("t5_rvalid3", rvalid_o, 4'b1000);
    chk("t5_rdata3", rdata_o, 32'hA1);
    tick(); beat(0, 1'b0, 1'b1, 16'h12, 32'h0);
    sample();
    chk("t5_gnt0", gnt_o, 4'b0001); chk("t5_rv_clear", rvalid_o, 0);
    chk("t5_ready0", beat_ready_o, 4'b0001);
    tick(); idle_in();
    sample();
    chk("t5_post_gnt", gnt_o, 0); chk("t5_rvalid0", rvalid_o, 4'b0001);
    chk("t5_rdata0", rdata_o, 32'hA2);

    // 6: reset during beat 2 of a 4-beat read
    tick(); req_i = 4'b0100; beat(2, 1'b0, 1'b0, 16'h10, 32'h0);
    sample(); chk("t6_pre_gnt", gnt_o, 0);
    tick();
    sample(); chk("t6_gnt", gnt_o, 4'b0100); chk("t6_ready", beat_ready_o, 4'b0100);
    tick(); beat(2, 1'b0, 1'b0, 16'h11, 32'h0); rst_i = 1'b1;
    sample();
    chk("t6_rv_beat1", rvalid_o, 4'b0100); chk("t6_rst_ready", beat_ready_o, 0);
    chk("t6_rst_addr", addr_o, 0);         chk("t6_rst_be", byte_en_o, 0);
    tick(); rst_i = 1'b0; req_i = 4'b1111;
    sample();
    chk("t6_post_gnt", gnt_o, 0); chk("t6_post_rvalid", rvalid_o, 0);
    chk("t6_post_ready", beat_ready_o, 0);
    tick(); idle_in();
    sample(); chk("t6_first_gnt", gnt_o, 4'b0001);
    tick();
    sample(); chk("t6_end_gnt", gnt_o, 0); chk("t6_end_rvalid", rvalid_o, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port RAM port (addr/write/write_en/byte_en/data, 1-cycle read latency) between NUM_REQ local requesters, such as AXI-to-RAM bridges, DMA engines and PMU dump logic.
- Once a requester is granted, it keeps the grant for a whole burst, ending on its last-flagged beat.
- Read data is returned with a one-hot valid to the requester that issued the read.
- The block sits between the requesters and the RAM macro port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 16, RAM word address width
DATA_WIDTH, 32, RAM data width
BYTE_WIDTH, 8, bits per byte lane
BATCH_WIDTH, DATA_WIDTH/BYTE_WIDTH, byte-enable width

Ports:
clk_in  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
req_i  input  NUM_REQ  per-requester burst request, held until last beat accepted
beat_valid_i  input  NUM_REQ  per-requester beat present this cycle
last_i  input  NUM_REQ  beat is final beat of burst
we_i  input  NUM_REQ  beat is a write (0 = read)
addr_i  input  NUM_REQ*ADDR_WIDTH  packed beat addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data
be_i  input  NUM_REQ*BATCH_WIDTH  packed byte enables
gnt_o  output  NUM_REQ  one-hot registered grant
beat_ready_o  output  NUM_REQ  beat accepted this cycle (one-hot, subset of gnt_o)
rvalid_o  output  NUM_REQ  one-hot read-data valid
rdata_o  output  DATA_WIDTH  read data (broadcast)
addr_o  output  ADDR_WIDTH  RAM address
write_o  output  DATA_WIDTH  RAM write data
write_en_o  output  1  RAM write enable
byte_en_o  output  BATCH_WIDTH  RAM byte enables
data_i  input  DATA_WIDTH  RAM read data, valid 1 cycle after address

Behaviour:

Reset
- rst_i sampled at clk_in: state=IDLE, gnt_o=0, rvalid_o=0, rd_pending=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority).
- While in reset all RAM controls are 0: addr_o=0, write_en_o=0, byte_en_o=0, write_o=0.
- Reset mid-burst drops the burst and any pending read return; no rvalid_o after reset.

FSM states: IDLE, BUSY.

IDLE
- gnt_o=0.
- If any req_i bit is set, select the first set bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
- Register the grant and rr_ptr=winner, then go to BUSY.
- Grant latency: req_i rising in cycle N gives gnt_o in cycle N+1.
- No RAM access is issued in IDLE.

BUSY (granted index g)
- beat_ready_o[g] = beat_valid_i[g], combinationally. All other beat_ready_o bits are 0.
- On an accepted beat:
  - addr_o = addr_i[g]; write_en_o = we_i[g]; write_o = wdata_i[g].
  - byte_en_o = be_i[g] for writes, all-ones for reads.
- With no accepted beat: write_en_o=0, byte_en_o=0. addr_o/write_o are don't-care but drive granted values.
- Leave BUSY for IDLE next cycle when either:
  - an accepted beat has last_i[g]=1, or
  - req_i[g] drops without a last beat (abandon; no error flagged).
- One idle bubble cycle always separates bursts. gnt_o clears the cycle after the last beat.

Read return
- An accepted read beat at cycle N sets rd_pending and rd_id=g.
- At N+1: rvalid_o[rd_id]=1 and rdata_o=data_i.
- This holds even if the grant has changed or dropped at N+1.
- Back-to-back reads give back-to-back rvalid. Writes produce no rvalid.

Invariants (assert in bench)
- gnt_o is one-hot or zero.
- beat_ready_o is a subset of gnt_o.
- write_en_o implies exactly one beat_ready_o bit is set.

Test Plan:
1. Reset with req_i=4'b0000 -> all outputs 0. Then req_i=4'b0001 at cycle 5 -> gnt_o=4'b0001 at cycle 6.
2. Requester 2 writes a 3-beat burst to addresses 0x10..0x12 with be=4'hF, data 0xA0..0xA2 -> write_en_o high 3 cycles with matching addr/data; gnt_o clears after the beat with last=1.
3. Requester 1 reads a 2-beat burst at 0x10, 0x11 with RAM model returning the stored data -> rvalid_o=4'b0010 for 2 consecutive cycles, each 1 cycle after acceptance, rdata_o=0xA0 then 0xA1.
4. All four requesters hold req_i=4'b1111 with 1-beat bursts -> grant order 0,1,2,3,0, with one IDLE cycle between each grant.
5. Requester 3 reads a single beat with last=1 while requester 0 is waiting -> rvalid_o[3] asserts on the same cycle gnt_o is still zero (bubble). The next cycle gnt_o=4'b0001.
6. rst_i asserted in the 2nd beat of a 4-beat read burst -> next cycle gnt_o=0, rvalid_o=0. Requester 0 is granted first after release.
